// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply, restoring divide.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiply.
module mdu_iter #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic [31:0] a_orig;
    logic        neg_main;
    logic        neg_rem;
    logic        b_zero;

    logic        accept;
    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        last;

    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_fin;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

`ifdef MDU_FAST_MUL_EN
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] fast_prod;
`endif

    assign busy      = (state != IDLE);
    assign accept    = start && (state == IDLE);
    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign is_signed = (op == OP_MULT) || (op == OP_DIV);
    assign abs_a     = (is_signed && a[31]) ? (32'd0 - a) : a;
    assign abs_b     = (is_signed && b[31]) ? (32'd0 - b) : b;
    assign last      = (count == 5'd31);

`ifdef MDU_FAST_MUL_EN
    assign ext_a     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign ext_b     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign fast_prod = ext_a * ext_b;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};
    assign mul_fin  = neg_main ? (64'd0 - mul_next) : mul_next;

    // Divide: acc = {partial remainder, dividend shifting into quotient}
    assign div_sh   = {acc[63:32], acc[31]};
    assign div_diff = div_sh - {1'b0, opnd};
    assign div_next = div_diff[32] ? {div_sh[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};
    assign quo      = div_next[31:0];
    assign rem      = div_next[63:32];
    assign div_lo   = b_zero ? DIV0_LO
                    : (neg_main ? (32'd0 - quo) : quo);
    assign div_hi   = b_zero ? a_orig
                    : (neg_rem ? (32'd0 - rem) : rem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
`ifndef MDU_FAST_MUL_EN
                if (accept && is_mul) begin
                    state_next = MUL;
                end
`endif
                if (accept && is_div) begin
                    state_next = DIV;
                end
            end
            MUL: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            DIV: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi       <= 32'd0;
            lo       <= 32'd0;
            done     <= 1'b0;
            count    <= 5'd0;
            acc      <= 64'd0;
            opnd     <= 32'd0;
            a_orig   <= 32'd0;
            neg_main <= 1'b0;
            neg_rem  <= 1'b0;
            b_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        count <= 5'd0;
                        case (op)
                            OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                                hi   <= fast_prod[63:32];
                                lo   <= fast_prod[31:0];
                                done <= 1'b1;
`else
                                acc      <= {32'd0, abs_b};
                                opnd     <= abs_a;
                                neg_main <= is_signed && (a[31] ^ b[31]);
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                acc      <= {32'd0, abs_a};
                                opnd     <= abs_b;
                                a_orig   <= a;
                                b_zero   <= (b == 32'd0);
                                neg_main <= is_signed && (a[31] ^ b[31]);
                                neg_rem  <= is_signed && a[31];
                            end
                            OP_MTHI: hi <= a;
                            OP_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 5'd1;
                    if (last) begin
                        hi   <= mul_fin[63:32];
                        lo   <= mul_fin[31:0];
                        done <= 1'b1;
                    end
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 5'd1;
                    if (last) begin
                        hi   <= div_hi;
                        lo   <= div_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: random and directed ops vs. a 64-bit arithmetic model.
module tb_mdu_iter;

    localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          e0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          edge_cnt = 0;
    bit          mon_en = 1'b0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_iter dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi   (hi),
        .lo   (lo),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [63:0] ref_model(input logic [2:0] o,
                                              input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] ux;
        logic [63:0] uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            3'd0: return 64'(sx * sy);
            3'd1: return ux * uy;
            3'd2: begin
                if (y == 32'd0) return {x, DIV0};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {x, DIV0};
                return {32'(ux % uy), 32'(ux / uy)};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t it;
            checks++;
            if (done) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done=1 with no pending op at edge %0d",
                             edge_cnt);
                end else begin
                    it = sb.pop_front();
                    if (hi !== it.hi || lo !== it.lo) begin
                        errors++;
                        $display("FAIL result: got hi=%h lo=%h want hi=%h lo=%h",
                                 hi, lo, it.hi, it.lo);
                    end
                    checks++;
                    if (edge_cnt - it.e0 != it.lat) begin
                        errors++;
                        $display("FAIL latency: got %0d want %0d",
                                 edge_cnt - it.e0, it.lat);
                    end
                    model_hi = it.hi;
                    model_lo = it.lo;
                end
            end else if (hi !== model_hi || lo !== model_lo) begin
                errors++;
                $display("FAIL hold: got hi=%h lo=%h want hi=%h lo=%h",
                         hi, lo, model_hi, model_lo);
            end
        end
    end

    task automatic wait_idle(input bit noise);
        for (int i = 0; i < 40 && busy; i++) begin
            if (noise && $urandom_range(7) == 0) begin
                start = 1'b1;
                op    = 3'($urandom);
                a     = $urandom;
                b     = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL timeout: busy=%b want 0 after 40 cycles", busy);
        end
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after E0.
    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit do_wait, input bit noise);
        exp_t        it;
        logic [63:0] r;
        bit          iter;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        iter = (o == 3'd2 || o == 3'd3) || ((o <= 3'd1) && !FAST);
        if (o <= 3'd3) begin
            r      = ref_model(o, x, y);
            it.hi  = r[63:32];
            it.lo  = r[31:0];
            it.e0  = edge_cnt;
            it.lat = iter ? 32 : 0;
            sb.push_back(it);
            checks++;
            if (busy !== iter) begin
                errors++;
                $display("FAIL busy_e0: got %b want %b op=%0d", busy, iter, o);
            end
        end else if (o <= 3'd5) begin
            if (o == 3'd4) model_hi = x;
            else model_lo = x;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL mt_flags: got busy=%b done=%b want 0 0", busy, done);
            end
        end else begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reserved: got busy=%b want 0", busy);
            end
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        a     = $urandom;
        b     = $urandom;
        if (do_wait) wait_idle(noise);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want 0 0 0 0",
                     hi, lo, busy, done);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        issue(3'd0, -32'sd7, 32'd3, 1, 0);
        issue(3'd2, -32'sd7, 32'd2, 1, 0);
        issue(3'd3, 32'd100, 32'd7, 1, 0);
        issue(3'd3, 32'd5, 32'd0, 1, 0);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        issue(3'd2, 32'h8000_0007, 32'd0, 1, 0);

        // MTHI while a divide is in flight must be dropped
        issue(3'd3, 32'd1000, 32'd9, 0, 0);
        start = 1'b1;
        op    = 3'd4;
        a     = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        wait_idle(0);
        issue(3'd4, 32'h1234_5678, 32'd0, 1, 0);
        issue(3'd5, 32'hCAFE_F00D, 32'd0, 1, 0);
        issue(3'd6, 32'hDEAD_BEEF, 32'd1, 1, 0);
        issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1, 0);

        // Abort a divide with reset sampled at E10
        issue(3'd3, 32'd1000, 32'd3, 0, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL abort: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (35) @(negedge clk);
        issue(3'd1, 32'd3, 32'd4, 1, 0);

        for (int n = 0; n < 200; n++) begin
            issue(3'($urandom), pick(), pick(), 1, 1);
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
